mem_bus_controller: RTL and testbench

Parametrised successor to the CPU memory interface. It arbitrates instruction fetches and data reads/writes from the soft CPU onto the shared external bus (flash + NVRAM, common address/data, per-chip active-low OE/WE, CE tied low). Unlike the current block, it has a real FSM, programmable wait states, a multi-byte fetch width, a request/done handshake and flash write protection. It sits between control_matrix and the board-level memory pins.

---
 rtl/mem_bus_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_bus_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_controller.sv
// Memory bus controller: arbitrates CPU instruction fetches and data reads/writes
// onto the shared flash/NVRAM bus with programmable wait states and flash write protection.
module mem_bus_controller #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int INSTR_BYTES    = 4,
  parameter int WAIT_CYCLES    = 2,
  parameter int FLASH_WRITABLE = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fetch_req,
  input  logic [ADDR_W-1:0]             fetch_addr,
  output logic [INSTR_BYTES*DATA_W-1:0] instruction,
  output logic                          instr_valid,
  input  logic                          rd_req,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_done,
  output logic                          wr_done,
  output logic                          wr_err,
  output logic                          busy,
  output logic [ADDR_W-1:0]             address_bus,
  inout  wire  [DATA_W-1:0]             data_bus,
  output logic                          flash_oe_n,
  output logic                          flash_we_n,
  output logic                          nvram_oe_n,
  output logic                          nvram_we_n
);

  localparam int          INSTR_W     = INSTR_BYTES * DATA_W;
  localparam int          BEAT_W      = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INSTR_BYTES - 1);
  localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_CYCLES);
  localparam bit          FLASH_WR_EN = (FLASH_WRITABLE != 0);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_bus_controller: WAIT_CYCLES must be within 0..15");
  end
  if (INSTR_BYTES < 1) begin : g_bad_instr
    $error("mem_bus_controller: INSTR_BYTES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RECOVER,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } busState;

  busState             state, stateNext;
  logic [3:0]          waitCount, waitNext;
  logic [BEAT_W-1:0]   beatCount, beatNext;
  logic                fetchMode, fetchNext;
  logic                rejectWrite, rejectNext;
  logic [DATA_W-1:0]   writeData, writeDataNext;
  logic                driveData, driveNext;
  logic [INSTR_W-1:0]  shiftReg, shiftNext, sampledShift;
  logic [ADDR_W-1:0]   addrNext;
  logic [INSTR_W-1:0]  instrNext;
  logic [DATA_W-1:0]   rdDataNext;
  logic                validNext, rdDoneNext, wrDoneNext, wrErrNext;
  logic                chipIsFlash, flashOeNext, flashWeNext, nvramOeNext, nvramWeNext;

  assign busy     = (state != IDLE);
  assign data_bus = driveData ? writeData : 'z;

  // Byte 0 enters first and ends up in the MSBs once all beats have shifted in.
  assign sampledShift = (shiftReg << DATA_W) | INSTR_W'(data_bus);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    stateNext     = state;
    waitNext      = waitCount;
    beatNext      = beatCount;
    fetchNext     = fetchMode;
    rejectNext    = rejectWrite;
    writeDataNext = writeData;
    shiftNext     = shiftReg;
    addrNext      = address_bus;
    instrNext     = instruction;
    rdDataNext    = rd_data;
    validNext     = 1'b0;
    rdDoneNext    = 1'b0;
    wrDoneNext    = 1'b0;
    wrErrNext     = 1'b0;

    case (state)
      IDLE: begin
        waitNext = '0;
        if (wr_req) begin
          addrNext      = mem_addr;
          writeDataNext = wr_data;
          fetchNext     = 1'b0;
          if (mem_addr[ADDR_W-1] && !FLASH_WR_EN) begin
            // Rejected flash write skips the bus entirely and reports on the next edge.
            rejectNext = 1'b1;
            stateNext  = WR_HOLD;
          end else begin
            rejectNext = 1'b0;
            stateNext  = WR_SETUP;
          end
        end else if (rd_req) begin
          addrNext  = mem_addr;
          fetchNext = 1'b0;
          stateNext = RD_STROBE;
        end else if (fetch_req) begin
          addrNext  = fetch_addr;
          fetchNext = 1'b1;
          beatNext  = '0;
          stateNext = RD_STROBE;
        end
      end

      RD_STROBE: begin
        if (waitCount == WAIT_LAST) begin
          if (fetchMode) begin
            shiftNext = sampledShift;
            if (beatCount == LAST_BEAT) begin
              instrNext = sampledShift;
              validNext = 1'b1;
              stateNext = IDLE;
            end else begin
              stateNext = RECOVER;
            end
          end else begin
            rdDataNext = data_bus;
            rdDoneNext = 1'b1;
            stateNext  = IDLE;
          end
        end else begin
          waitNext = waitCount + 4'd1;
        end
      end

      RECOVER: begin
        addrNext  = address_bus + ADDR_W'(1);
        beatNext  = beatCount + BEAT_W'(1);
        waitNext  = '0;
        stateNext = RD_STROBE;
      end

      WR_SETUP: begin
        waitNext  = '0;
        stateNext = WR_STROBE;
      end

      WR_STROBE: begin
        if (waitCount == WAIT_LAST) begin
          stateNext = WR_HOLD;
        end else begin
          waitNext = waitCount + 4'd1;
        end
      end

      WR_HOLD: begin
        wrDoneNext = 1'b1;
        wrErrNext  = rejectWrite;
        rejectNext = 1'b0;
        stateNext  = IDLE;
      end

      default: stateNext = IDLE;
    endcase

    // Strobes are registered from the next state so the pins never glitch on decode.
    chipIsFlash = addrNext[ADDR_W-1];
    flashOeNext = !((stateNext == RD_STROBE) &&  chipIsFlash);
    nvramOeNext = !((stateNext == RD_STROBE) && !chipIsFlash);
    flashWeNext = !((stateNext == WR_STROBE) &&  chipIsFlash);
    nvramWeNext = !((stateNext == WR_STROBE) && !chipIsFlash);
    driveNext   = (stateNext inside {WR_SETUP, WR_STROBE, WR_HOLD}) && !rejectNext;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      waitCount   <= '0;
      beatCount   <= '0;
      fetchMode   <= 1'b0;
      rejectWrite <= 1'b0;
      writeData   <= '0;
      driveData   <= 1'b0;
      shiftReg    <= '0;
      address_bus <= '0;
      instruction <= '0;
      rd_data     <= '0;
      instr_valid <= 1'b0;
      rd_done     <= 1'b0;
      wr_done     <= 1'b0;
      wr_err      <= 1'b0;
      flash_oe_n  <= 1'b1;
      flash_we_n  <= 1'b1;
      nvram_oe_n  <= 1'b1;
      nvram_we_n  <= 1'b1;
    end else begin
      state       <= stateNext;
      waitCount   <= waitNext;
      beatCount   <= beatNext;
      fetchMode   <= fetchNext;
      rejectWrite <= rejectNext;
      writeData   <= writeDataNext;
      driveData   <= driveNext;
      shiftReg    <= shiftNext;
      address_bus <= addrNext;
      instruction <= instrNext;
      rd_data     <= rdDataNext;
      instr_valid <= validNext;
      rd_done     <= rdDoneNext;
      wr_done     <= wrDoneNext;
      wr_err      <= wrErrNext;
      flash_oe_n  <= flashOeNext;
      flash_we_n  <= flashWeNext;
      nvram_oe_n  <= nvramOeNext;
      nvram_we_n  <= nvramWeNext;
    end
  end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller (defaults: 16-bit address, 8-bit data, 4-byte fetch,
// 2 wait states, flash writes rejected) against a flat 64 KiB flash+NVRAM bus model.
module tb_mem_bus_controller;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] mem_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        rd_done;
  logic        wr_done;
  logic        wr_err;
  logic        busy;
  logic [15:0] address_bus;
  wire  [7:0]  data_bus;
  logic        flash_oe_n, flash_we_n, nvram_oe_n, nvram_we_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem [0:65535];

  // Released bus floats high, so an undriven data_bus reads 8'hFF.
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (data_bus[i]);
  end
  assign data_bus = (!flash_oe_n || !nvram_oe_n) ? mem[address_bus] : 8'bz;

  always @(posedge clock) begin
    if (!nvram_we_n) mem[address_bus] = data_bus;
    if (!flash_we_n) mem[address_bus] = data_bus;
  end

  mem_bus_controller dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .mem_addr    (mem_addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_done     (rd_done),
    .wr_done     (wr_done),
    .wr_err      (wr_err),
    .busy        (busy),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .flash_oe_n  (flash_oe_n),
    .flash_we_n  (flash_we_n),
    .nvram_oe_n  (nvram_oe_n),
    .nvram_we_n  (nvram_we_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit k of each trace holds the value seen just after edge E0+k.
  logic [31:0] trFlashOe, trFlashWe, trNvOe, trNvWe;
  logic [31:0] trValid, trRdDone, trWrDone, trWrErr, trBusy;
  logic [15:0] trAddr [32];
  logic [7:0]  trData [32];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic record(input int k);
    trFlashOe[k] = flash_oe_n;
    trFlashWe[k] = flash_we_n;
    trNvOe[k]    = nvram_oe_n;
    trNvWe[k]    = nvram_we_n;
    trValid[k]   = instr_valid;
    trRdDone[k]  = rd_done;
    trWrDone[k]  = wr_done;
    trWrErr[k]   = wr_err;
    trBusy[k]    = busy;
    trAddr[k]    = address_bus;
    trData[k]    = data_bus;
  endtask

  // Requests must already be driven; the next edge is the accept edge E0.
  task automatic capture(input int n);
    trFlashOe = '1; trFlashWe = '1; trNvOe = '1; trNvWe = '1;
    trValid = '0; trRdDone = '0; trWrDone = '0; trWrErr = '0; trBusy = '0;
    @(posedge clock); #1;
    fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    record(0);
    for (int k = 1; k < n; k++) begin
      @(posedge clock); #1;
      record(k);
    end
  endtask

  // Expected OE trace for a 4-beat fetch with 2 wait states: 4-cycle beat period, OE low
  // in the first three cycles of each beat whose chip bit is set in sel.
  function automatic logic [31:0] fetchOe(input logic [3:0] sel);
    logic [31:0] v;
    v = '1;
    for (int k = 0; k < 16; k++)
      if (sel[k / 4] && (k % 4 != 3)) v[k] = 1'b0;
    return v;
  endfunction

  initial begin
    reset = 1'b1; fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    fetch_addr = '0; mem_addr = '0; wr_data = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h8000] = 8'h12; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h56; mem[16'h8003] = 8'h78;
    mem[16'h7FFE] = 8'hAA; mem[16'h7FFF] = 8'hBB;
    mem[16'hFFFE] = 8'hC1; mem[16'hFFFF] = 8'hD2; mem[16'h0000] = 8'hE3; mem[16'h0001] = 8'hF4;
    mem[16'h9000] = 8'h77; mem[16'h1000] = 8'h66;

    // Reset values
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset strobes", {flash_oe_n, flash_we_n, nvram_oe_n, nvram_we_n}, 4'hF);
    check("reset data_bus released", data_bus, 8'hFF);
    check("reset busy", busy, 1'b0);
    check("reset instruction", instruction, 32'h0);
    check("reset address_bus", address_bus, 16'h0);
    check("reset rd_data", rd_data, 8'h0);
    check("reset pulses", {instr_valid, rd_done, wr_done, wr_err}, 4'h0);
    repeat (2) @(posedge clock);
    #1 check("idle strobes", {flash_oe_n, flash_we_n, nvram_oe_n, nvram_we_n}, 4'hF);

    // Flash fetch at 0x8000
    fetch_addr = 16'h8000; fetch_req = 1'b1;
    capture(17);
    check("fetch8000 flash_oe trace", trFlashOe, fetchOe(4'b1111));
    check("fetch8000 nvram_oe trace", trNvOe, 32'hFFFF_FFFF);
    check("fetch8000 we traces", {trFlashWe, trNvWe}, 64'hFFFF_FFFF_FFFF_FFFF);
    check("fetch8000 instr_valid trace", trValid, 32'h0000_8000);
    check("fetch8000 instruction", instruction, 32'h1234_5678);
    check("fetch8000 beat addrs", {trAddr[0], trAddr[4], trAddr[8], trAddr[12]}, 64'h8000_8001_8002_8003);
    check("fetch8000 busy k0/k15", {trBusy[0], trBusy[15]}, 2'b10);

    // NVRAM write 0x0010 <= 0xA5
    mem_addr = 16'h0010; wr_data = 8'hA5; wr_req = 1'b1;
    capture(7);
    check("wr0010 nvram_we trace", trNvWe, 32'hFFFF_FFF1);
    check("wr0010 flash strobes", {trFlashOe, trFlashWe}, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr0010 nvram_oe trace", trNvOe, 32'hFFFF_FFFF);
    for (int k = 0; k < 5; k++) check($sformatf("wr0010 data k%0d", k), trData[k], 8'hA5);
    check("wr0010 data released k5", trData[5], 8'hFF);
    check("wr0010 wr_done trace", trWrDone, 32'h0000_0020);
    check("wr0010 wr_err trace", trWrErr, 32'h0);
    check("wr0010 address", trAddr[0], 16'h0010);
    check("wr0010 memory", mem[16'h0010], 8'hA5);

    // Read it back
    mem_addr = 16'h0010; rd_req = 1'b1;
    capture(5);
    check("rd0010 nvram_oe trace", trNvOe, 32'hFFFF_FFF8);
    check("rd0010 rd_done trace", trRdDone, 32'h0000_0008);
    check("rd0010 rd_data", rd_data, 8'hA5);

    // Rejected flash write
    mem_addr = 16'h9000; wr_data = 8'h3C; wr_req = 1'b1;
    capture(3);
    check("wr9000 wr_done trace", trWrDone, 32'h0000_0002);
    check("wr9000 wr_err trace", trWrErr, 32'h0000_0002);
    check("wr9000 we traces", {trFlashWe, trNvWe}, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr9000 data released", {trData[0], trData[1], trData[2]}, 24'hFFFFFF);
    check("wr9000 busy k0/k2", {trBusy[0], trBusy[2]}, 2'b10);
    check("wr9000 flash cell", mem[16'h9000], 8'h77);
    check("wr9000 nvram cell", mem[16'h1000], 8'h66);

    // Fetch crossing NVRAM -> flash
    fetch_addr = 16'h7FFE; fetch_req = 1'b1;
    capture(16);
    check("fetch7ffe nvram_oe trace", trNvOe, fetchOe(4'b0011));
    check("fetch7ffe flash_oe trace", trFlashOe, fetchOe(4'b1100));
    check("fetch7ffe beat addrs", {trAddr[0], trAddr[4], trAddr[8], trAddr[12]}, 64'h7FFE_7FFF_8000_8001);
    check("fetch7ffe instruction", instruction, 32'hAABB_1234);
    check("fetch7ffe instr_valid trace", trValid, 32'h0000_8000);

    // Fetch wrapping past the top of the address space
    fetch_addr = 16'hFFFE; fetch_req = 1'b1;
    capture(16);
    check("fetchfffe beat addrs", {trAddr[0], trAddr[4], trAddr[8], trAddr[12]}, 64'hFFFE_FFFF_0000_0001);
    check("fetchfffe flash_oe trace", trFlashOe, fetchOe(4'b0011));
    check("fetchfffe nvram_oe trace", trNvOe, fetchOe(4'b1100));
    check("fetchfffe instruction", instruction, 32'hC1D2_E3F4);

    // Simultaneous requests: only the write runs
    fetch_addr = 16'h8000; mem_addr = 16'h0020; wr_data = 8'h5A;
    fetch_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
    capture(20);
    check("simul nvram_we trace", trNvWe, 32'hFFFF_FFF1);
    check("simul oe traces", {trFlashOe, trNvOe}, 64'hFFFF_FFFF_FFFF_FFFF);
    check("simul wr_done trace", trWrDone, 32'h0000_0020);
    check("simul dropped pulses", {trValid, trRdDone}, 64'h0);
    check("simul memory", mem[16'h0020], 8'h5A);
    check("simul instruction kept", instruction, 32'hC1D2_E3F4);

    // Reset in the middle of a write
    mem_addr = 16'h0030; wr_data = 8'h99; wr_req = 1'b1;
    @(posedge clock); #1;
    wr_req = 1'b0;
    check("rstwr setup we", nvram_we_n, 1'b1);
    @(posedge clock); #1;
    check("rstwr strobe we", nvram_we_n, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rstwr we at reset edge", {flash_we_n, nvram_we_n}, 2'b11);
    check("rstwr data released", data_bus, 8'hFF);
    check("rstwr busy", busy, 1'b0);
    reset = 1'b0;
    trWrDone = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      trWrDone[k] = wr_done;
    end
    check("rstwr no wr_done", trWrDone, 32'h0);

    mem_addr = 16'h0010; rd_req = 1'b1;
    capture(5);
    check("post-reset rd_done trace", trRdDone, 32'h0000_0008);
    check("post-reset rd_data", rd_data, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
